tt_uio_arbiter: RTL and testbench



---
 rtl/tt_uio_arb_pkg.sv | 23 ++
 rtl/tt_rr_picker.sv | 36 +++
 rtl/tt_uio_arbiter.sv | 170 +++++++++++++++++
 tb/tb_tt_uio_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_uio_arb_pkg.sv
// Shared types and sizing helpers for the uio pin-bank arbiter.
package tt_uio_arb_pkg;

  // Pin-bank byte width (uio_out / uio_oe / uio_in).
  localparam int BYTE_W = 8;

  // Arbiter phases: IDLE arbitrates, GRANT drives the pins, TURN keeps
  // the bank released so two drivers never overlap.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } arb_state_e;

  // Width of a counter that has to reach n-1 (never narrower than 1 bit).
  function automatic int cnt_width(input int n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/tt_rr_picker.sv
// Round-robin winner selection: first requester set when scanning
// last+1, last+2, ... modulo NREQ. Purely combinational.
module tt_rr_picker #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [IDX_W-1:0] winner_o,
  output logic             any_req_o
);

  int   cand;
  logic found;

  // Walk the ring starting just after the previous owner; the previous
  // owner itself is visited last, so it only wins when alone.
  always_comb begin
    winner_o = '0;
    found    = 1'b0;
    cand     = 0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = int'(last_i) + i;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      if (!found && req_i[cand[IDX_W-1:0]]) begin
        found    = 1'b1;
        winner_o = cand[IDX_W-1:0];
      end
    end
  end

  assign any_req_o = |req_i;

endmodule

// File: rtl/tt_uio_arbiter.sv
// Shares the bidirectional uio pin bank among NREQ requesters.
// Round-robin grants with a bounded burst, and a forced turnaround
// window (uio_oe=0) between every two grants.
//
// Handshake: req_i[k] is a level. The grant is gnt_o[k] (registered,
// one-hot). While gnt_o[k] is high the pins follow data_i/oe_i slice k
// combinationally; dropping req_i[k] ends the grant at the next edge.
// rd_valid_o is gnt_o delayed one cycle and tags rd_data_o (uio_in
// registered once) with its owner.
module tt_uio_arbiter
  import tt_uio_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4,
  parameter int TURN_CYC  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [NREQ-1:0]        req_i,
  input  logic [BYTE_W*NREQ-1:0] data_i,
  input  logic [BYTE_W*NREQ-1:0] oe_i,
  output logic [NREQ-1:0]        gnt_o,
  output logic                   busy_o,
  output logic [BYTE_W-1:0]      uio_out,
  output logic [BYTE_W-1:0]      uio_oe,
  input  logic [BYTE_W-1:0]      uio_in,
  output logic [BYTE_W-1:0]      rd_data_o,
  output logic [NREQ-1:0]        rd_valid_o,
  output arb_state_e             dbg_state_o
);

  localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W  = cnt_width(MAX_BURST);
  localparam int TCNT_W = cnt_width(TURN_CYC);
  localparam logic [IDX_W-1:0]  LAST_RST  = IDX_W'(NREQ - 1);
  localparam logic [CNT_W-1:0]  BURST_TOP = CNT_W'(MAX_BURST - 1);
  localparam logic [TCNT_W-1:0] TURN_TOP  = TCNT_W'(TURN_CYC - 1);

  arb_state_e          state_q;
  logic [IDX_W-1:0]    owner_q;
  logic [IDX_W-1:0]    last_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic [TCNT_W-1:0]   tcnt_q;
  logic [TCNT_W-1:0]   tcnt_d;
  logic [NREQ-1:0]     gnt_q;
  logic [BYTE_W-1:0]   rd_data_q;
  logic [NREQ-1:0]     rd_valid_q;

  logic [IDX_W-1:0]    pick_idx;
  logic                any_req;
  logic                burst_end;
  logic                grant_done;
  logic                turn_end;
  logic [BYTE_W-1:0]   sel_data;
  logic [BYTE_W-1:0]   sel_oe;

  tt_rr_picker #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req_i     (req_i),
    .last_i    (last_q),
    .winner_o  (pick_idx),
    .any_req_o (any_req)
  );

  // Counter increments and exit conditions. A release that lands on the
  // last burst cycle is a single exit, not two.
  always_comb begin
    cnt_d      = cnt_q + CNT_W'(1);
    tcnt_d     = tcnt_q + TCNT_W'(1);
    burst_end  = (cnt_q == BURST_TOP);
    grant_done = !req_i[owner_q] || burst_end;
    turn_end   = (tcnt_q == TURN_TOP);
  end

  // Arbitration FSM: owner, last owner, burst/turnaround counters and the
  // registered one-hot grant. en only gates new grants from IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      gnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en && any_req) begin
            owner_q <= pick_idx;
            gnt_q   <= NREQ'(1) << pick_idx;
            cnt_q   <= '0;
            state_q <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          cnt_q <= cnt_d;
          if (grant_done) begin
            gnt_q   <= '0;
            last_q  <= owner_q;
            tcnt_q  <= '0;
            state_q <= ST_TURN;
          end
        end
        ST_TURN: begin
          tcnt_q <= tcnt_d;
          if (turn_end) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  // Select the owner's byte and enable mask; non-owners never reach the pins.
  always_comb begin
    sel_data = '0;
    sel_oe   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (owner_q == IDX_W'(k)) begin
        sel_data = data_i[BYTE_W*k +: BYTE_W];
        sel_oe   = oe_i[BYTE_W*k +: BYTE_W];
      end
    end
  end

  // Pins are released outside GRANT. Gating on the registered state means
  // an asserted reset drops uio_oe at once, without waiting for a clock.
  always_comb begin
    uio_out = '0;
    uio_oe  = '0;
    if (state_q == ST_GRANT) begin
      uio_out = sel_data;
      uio_oe  = sel_oe;
    end
  end

  // Readback path: capture uio_in every cycle and tag it with last cycle's grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= '0;
    end else begin
      rd_data_q  <= uio_in;
      rd_valid_q <= gnt_q;
    end
  end

  assign gnt_o       = gnt_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign rd_data_o   = rd_data_q;
  assign rd_valid_o  = rd_valid_q;
  assign dbg_state_o = state_q;

  // Invariants: at most one grant, grant only in GRANT, pins released otherwise.
  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(gnt_q));
  a_gnt_in_grant : assert property (@(posedge clk) disable iff (!rst_n)
    ((gnt_q != '0) == (state_q == ST_GRANT)));
  a_oe_released : assert property (@(posedge clk) disable iff (!rst_n)
    ((state_q != ST_GRANT) |-> (uio_oe == '0)));

endmodule

// File: tb/tb_tt_uio_arbiter.sv
// Self-checking bench for tt_uio_arbiter: a cycle-level reference model
// pushes the expected outputs of every clock edge into exp_q, and an
// independent monitor pops and compares them. Directed checks cover reset,
// grant order, period and the asynchronous reset behaviour.
module tb_tt_uio_arbiter;
  import tt_uio_arb_pkg::*;

  localparam int NREQ      = 4;
  localparam int MAX_BURST = 4;
  localparam int TURN_CYC  = 1;
  localparam int IDX_W     = 2;
  localparam int EXP_W     = 2*NREQ + 25;

  logic                clk;
  logic                rst_n;
  logic                en;
  logic [NREQ-1:0]     req_i;
  logic [8*NREQ-1:0]   data_i;
  logic [8*NREQ-1:0]   oe_i;
  logic [NREQ-1:0]     gnt_o;
  logic                busy_o;
  logic [7:0]          uio_out;
  logic [7:0]          uio_oe;
  logic [7:0]          uio_in;
  logic [7:0]          rd_data_o;
  logic [NREQ-1:0]     rd_valid_o;
  arb_state_e          dbg_state;

  tt_uio_arbiter #(
    .NREQ      (NREQ),
    .MAX_BURST (MAX_BURST),
    .TURN_CYC  (TURN_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .req_i       (req_i),
    .data_i      (data_i),
    .oe_i        (oe_i),
    .gnt_o       (gnt_o),
    .busy_o      (busy_o),
    .uio_out     (uio_out),
    .uio_oe      (uio_oe),
    .uio_in      (uio_in),
    .rd_data_o   (rd_data_o),
    .rd_valid_o  (rd_valid_o),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit sb_on = 1'b0;
  bit fix1  = 1'b0;
  int gl_owner[$];
  int gl_cycle[$];

  // Reference model: who owns the bank, how many burst cycles it used,
  // how many turnaround cycles remain, who owned it last.
  bit              m_granted;
  int              m_owner;
  int              m_last;
  int              m_used;
  int              m_turn_left;
  logic [NREQ-1:0] m_gnt_prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic bit_of(input logic [NREQ-1:0] v, input int i);
    logic [31:0] t;
    t = i;
    return v[t[IDX_W-1:0]];
  endfunction

  task automatic model_reset();
    m_granted   = 1'b0;
    m_owner     = 0;
    m_last      = NREQ - 1;
    m_used      = 0;
    m_turn_left = 0;
    m_gnt_prev  = '0;
  endtask

  // One clock edge of the model, using the inputs present at that edge.
  task automatic model_step();
    logic [NREQ-1:0]   e_gnt;
    logic              e_busy;
    logic [7:0]        e_out;
    logic [7:0]        e_oe;
    logic [7:0]        e_rd;
    logic [NREQ-1:0]   e_rdv;
    logic [8*NREQ-1:0] sh;
    bit                found;
    int                j;
    e_rd  = uio_in;
    e_rdv = m_gnt_prev;
    if (m_granted) begin
      m_used++;
      if (!bit_of(req_i, m_owner) || m_used == MAX_BURST) begin
        m_granted   = 1'b0;
        m_last      = m_owner;
        m_turn_left = TURN_CYC;
      end
    end else if (m_turn_left > 0) begin
      m_turn_left--;
    end else if (en && req_i != '0) begin
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
        j = (m_last + k) % NREQ;
        if (!found && bit_of(req_i, j)) begin
          found   = 1'b1;
          m_owner = j;
        end
      end
      m_granted = 1'b1;
      m_used    = 0;
    end
    e_gnt  = m_granted ? (NREQ'(1) << m_owner) : '0;
    e_busy = m_granted || (m_turn_left > 0);
    e_out  = '0;
    e_oe   = '0;
    if (m_granted) begin
      sh    = data_i >> (8*m_owner);
      e_out = sh[7:0];
      sh    = oe_i >> (8*m_owner);
      e_oe  = sh[7:0];
    end
    exp_q.push_back({e_gnt, e_busy, e_out, e_oe, e_rd, e_rdv});
    m_gnt_prev = e_gnt;
  endtask

  // Model process: advances on every rising edge while the scoreboard is on.
  initial begin
    forever begin
      @(posedge clk);
      if (sb_on) model_step();
    end
  end

  // Monitor: compares DUT outputs against the oldest expectation, and logs
  // the owner and cycle of each new grant.
  initial begin
    logic [EXP_W-1:0] e;
    logic [NREQ-1:0]  prev_g;
    int               ow;
    prev_g = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("gnt_o",      32'(gnt_o),      32'(e[EXP_W-1:NREQ+25]));
        check("busy_o",     32'(busy_o),     32'(e[NREQ+24]));
        check("uio_out",    32'(uio_out),    32'(e[NREQ+23:NREQ+16]));
        check("uio_oe",     32'(uio_oe),     32'(e[NREQ+15:NREQ+8]));
        check("rd_data_o",  32'(rd_data_o),  32'(e[NREQ+7:NREQ]));
        check("rd_valid_o", 32'(rd_valid_o), 32'(e[NREQ-1:0]));
      end
      if (gnt_o != '0 && prev_g == '0) begin
        ow = -1;
        for (int k = 0; k < NREQ; k++) begin
          if (gnt_o == (NREQ'(1) << k)) ow = k;
        end
        gl_owner.push_back(ow);
        gl_cycle.push_back(cyc);
      end
      prev_g = gnt_o;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [NREQ-1:0] r, input logic e, input int n);
    repeat (n) begin
      @(negedge clk);
      req_i  = r;
      en     = e;
      uio_in = 8'($urandom);
      for (int k = 0; k < NREQ; k++) begin
        data_i[8*k +: 8] = 8'($urandom);
        oe_i[8*k +: 8]   = 8'($urandom);
      end
      if (fix1) begin
        data_i[15:8] = 8'hA5;
        oe_i[15:8]   = 8'hFF;
      end
    end
  endtask

  task automatic do_reset();
    sb_on = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    req_i = '0;
    en    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_gnt",      32'(gnt_o),      32'h0);
    check("rst_busy",     32'(busy_o),     32'h0);
    check("rst_uio_out",  32'(uio_out),    32'h0);
    check("rst_uio_oe",   32'(uio_oe),     32'h0);
    check("rst_rd_data",  32'(rd_data_o),  32'h0);
    check("rst_rd_valid", 32'(rd_valid_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    gl_owner.delete();
    gl_cycle.delete();
    sb_on = 1'b1;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int c0;
    logic [NREQ-1:0] r;
    rst_n  = 1'b0;
    en     = 1'b0;
    req_i  = '0;
    data_i = '0;
    oe_i   = '0;
    uio_in = '0;

    // Single requester 1 with fixed byte: latency 1, 6-cycle grant period.
    do_reset();
    c0   = cyc;
    fix1 = 1'b1;
    drive(4'b0010, 1'b1, 20);
    fix1 = 1'b0;
    check("single_ngrants", 32'(gl_owner.size() >= 3), 32'h1);
    if (gl_owner.size() >= 3) begin
      check("single_owner",   32'(gl_owner[0]), 32'd1);
      check("single_latency", 32'(gl_cycle[0] - c0), 32'd2);
      check("single_period1", 32'(gl_cycle[1] - gl_cycle[0]), 32'd6);
      check("single_period2", 32'(gl_cycle[2] - gl_cycle[1]), 32'd6);
    end

    // Contention 0 and 2: alternate 0,2,0,2, one burst + turn + idle apart.
    do_reset();
    drive(4'b0101, 1'b1, 26);
    check("cont_ngrants", 32'(gl_owner.size() >= 4), 32'h1);
    if (gl_owner.size() >= 4) begin
      check("cont_order0", 32'(gl_owner[0]), 32'd0);
      check("cont_order1", 32'(gl_owner[1]), 32'd2);
      check("cont_order2", 32'(gl_owner[2]), 32'd0);
      check("cont_order3", 32'(gl_owner[3]), 32'd2);
      check("cont_gap",    32'(gl_cycle[1] - gl_cycle[0]), 32'd6);
    end

    // Wrap-around between requesters 3 and 0.
    do_reset();
    drive(4'b1001, 1'b1, 20);
    check("wrap_ngrants", 32'(gl_owner.size() >= 3), 32'h1);
    if (gl_owner.size() >= 3) begin
      check("wrap_order0", 32'(gl_owner[0]), 32'd0);
      check("wrap_order1", 32'(gl_owner[1]), 32'd3);
      check("wrap_order2", 32'(gl_owner[2]), 32'd0);
    end

    // Early release after two grant cycles, then release on the last burst cycle.
    do_reset();
    drive(4'b0100, 1'b1, 3);
    drive(4'b0000, 1'b1, 4);
    drive(4'b0100, 1'b1, 4);
    drive(4'b0000, 1'b1, 4);
    check("early_ngrants", 32'(gl_owner.size()), 32'd2);

    // Enable low blocks new grants but not one in progress.
    do_reset();
    drive(4'b1111, 1'b0, 8);
    check("en_off_nogrant", 32'(gl_owner.size()), 32'd0);
    drive(4'b1111, 1'b1, 1);
    drive(4'b1111, 1'b0, 10);
    check("en_one_grant", 32'(gl_owner.size()), 32'd1);

    // Reset asserted mid-grant releases the pins before any clock edge.
    do_reset();
    fix1 = 1'b1;
    drive(4'b0010, 1'b1, 2);
    check("mid_pre_oe",  32'(uio_oe), 32'hFF);
    check("mid_pre_gnt", 32'(gnt_o),  32'h2);
    sb_on = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_oe",   32'(uio_oe),  32'h0);
    check("async_out",  32'(uio_out), 32'h0);
    check("async_gnt",  32'(gnt_o),   32'h0);
    check("async_busy", 32'(busy_o),  32'h0);
    fix1 = 1'b0;

    // Randomized traffic: requests held for a few cycles, en mostly high.
    do_reset();
    r = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) r = NREQ'($urandom);
      drive(r, ($urandom_range(0, 7) != 0), 1);
    end
    drive(4'b0000, 1'b1, 8);
    sb_on = 1'b0;
    @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
